// File: rtl/match_controller.sv
// Pong match sequencer: turns ball-out events into scoreboard goal strobes and
// drives the ball through serve, goal-pause, pause and game-over phases.
module match_controller #(
  parameter int MAX_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int GOAL_FRAMES  = 90
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       pause,
  input  logic       out_left,
  input  logic       out_right,
  output logic       goal_ply1,
  output logic       goal_ply2,
  output logic       score_clr,
  output logic       serve,
  output logic       ball_dir,
  output logic       freeze,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'b000;
  localparam logic [2:0] S_SERVE  = 3'b001;
  localparam logic [2:0] S_PLAY   = 3'b010;
  localparam logic [2:0] S_PAUSED = 3'b011;
  localparam logic [2:0] S_GOAL   = 3'b100;
  localparam logic [2:0] S_OVER   = 3'b101;

  localparam logic [3:0] MAX_S   = 4'(MAX_SCORE);
  localparam logic [7:0] SERVE_N = 8'(SERVE_FRAMES);
  localparam logic [7:0] GOAL_N  = 8'(GOAL_FRAMES);

  logic [2:0] state_q, state_d;
  logic       start_q, pause_q;
  logic [3:0] s1_q, s1_d, s2_q, s2_d;
  logic [7:0] fc_q, fc_d;
  logic       g1_q, g1_d, g2_q, g2_d;
  logic       serve_q, serve_d;
  logic       dir_q, dir_d;
  logic [1:0] win_q, win_d;
  logic       clr_q, frz_q;

  logic       start_e, pause_e;
  logic [3:0] s1_inc, s2_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= MAX_S) ? MAX_S : s + 4'd1;
  endfunction

  assign start_e = start & ~start_q;
  assign pause_e = pause & ~pause_q;
  assign s1_inc  = sat_inc(s1_q);
  assign s2_inc  = sat_inc(s2_q);

  always_comb begin
    state_d = state_q;
    fc_d    = fc_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    serve_d = 1'b0;
    dir_d   = dir_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          state_d = S_SERVE;
          fc_d    = SERVE_N;
          dir_d   = 1'b0;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (fc_q == 8'd0) begin
            serve_d = 1'b1;
            state_d = S_PLAY;
          end else begin
            fc_d = fc_q - 8'd1;
          end
        end
      end
      S_PLAY: begin
        // out_left outranks out_right when both arrive together
        if (out_left) begin
          s2_d    = s2_inc;
          g2_d    = 1'b1;
          dir_d   = 1'b0;
          fc_d    = GOAL_N;
          state_d = S_GOAL;
          if (s2_inc == MAX_S) win_d = 2'b10;
        end else if (out_right) begin
          s1_d    = s1_inc;
          g1_d    = 1'b1;
          dir_d   = 1'b1;
          fc_d    = GOAL_N;
          state_d = S_GOAL;
          if (s1_inc == MAX_S) win_d = 2'b01;
        end else if (pause_e) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause_e) state_d = S_PLAY;
      end
      S_GOAL: begin
        // strobe is held until the slow scoreboard clock has seen a frame edge
        if (frame_tick) begin
          g1_d = 1'b0;
          g2_d = 1'b0;
          if (fc_q == 8'd0) begin
            if (win_q != 2'b00) begin
              state_d = S_OVER;
            end else begin
              state_d = S_SERVE;
              fc_d    = SERVE_N;
            end
          end else begin
            fc_d = fc_q - 8'd1;
          end
        end
      end
      S_OVER: begin
        if (start_e) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        g1_d    = 1'b0;
        g2_d    = 1'b0;
      end
    endcase
    if (state_d == S_IDLE) begin
      s1_d  = 4'd0;
      s2_d  = 4'd0;
      win_d = 2'b00;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      s1_q    <= 4'd0;
      s2_q    <= 4'd0;
      fc_q    <= 8'd0;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      serve_q <= 1'b0;
      dir_q   <= 1'b0;
      win_q   <= 2'b00;
      clr_q   <= 1'b1;
      frz_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      start_q <= start;
      pause_q <= pause;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      fc_q    <= fc_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      serve_q <= serve_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      clr_q   <= (state_d == S_IDLE);
      frz_q   <= (state_d != S_PLAY);
    end
  end

  assign state     = state_q;
  assign goal_ply1 = g1_q;
  assign goal_ply2 = g2_q;
  assign score_clr = clr_q;
  assign serve     = serve_q;
  assign ball_dir  = dir_q;
  assign freeze    = frz_q;
  assign winner    = win_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: hand-derived vector table for the directed
// scenarios, then random button/ball traffic against a reference model.
module tb_match_controller;

  localparam int MAXS = 3;
  localparam int SF   = 2;
  localparam int GF   = 1;

  localparam logic [2:0] IDL = 3'd0, SRV = 3'd1, PLY = 3'd2, PSD = 3'd3, GOL = 3'd4, OVR = 3'd5;

  logic px_clk = 1'b0;
  logic reset = 1'b1, frame_tick = 1'b0, start = 1'b0, pause = 1'b0;
  logic out_left = 1'b0, out_right = 1'b0;
  logic goal_ply1, goal_ply2, score_clr, serve, ball_dir, freeze;
  logic [1:0] winner;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  match_controller #(.MAX_SCORE(MAXS), .SERVE_FRAMES(SF), .GOAL_FRAMES(GF)) dut (
    .px_clk(px_clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .pause(pause), .out_left(out_left), .out_right(out_right),
    .goal_ply1(goal_ply1), .goal_ply2(goal_ply2), .score_clr(score_clr),
    .serve(serve), .ball_dir(ball_dir), .freeze(freeze), .winner(winner),
    .state(state)
  );

  always #5 px_clk = ~px_clk;

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_SERVE = 1, P_PLAY = 2, P_PAUSED = 3, P_GOAL = 4, P_OVER = 5;
  int m_phase = P_IDLE, m_ticks = 0, m_s1 = 0, m_s2 = 0;
  bit m_g1 = 0, m_g2 = 0, m_serve = 0, m_dir = 0, m_pst = 0, m_ppa = 0;

  function automatic int m_winner();
    if (m_s1 == MAXS) return 1;
    if (m_s2 == MAXS) return 2;
    return 0;
  endfunction

  task automatic model_step();
    bit se, pe;
    if (reset) begin
      m_phase = P_IDLE; m_ticks = 0; m_s1 = 0; m_s2 = 0;
      m_g1 = 0; m_g2 = 0; m_serve = 0; m_dir = 0; m_pst = 0; m_ppa = 0;
      return;
    end
    se = start && !m_pst;
    pe = pause && !m_ppa;
    m_pst = start;
    m_ppa = pause;
    m_serve = 0;
    case (m_phase)
      P_IDLE: if (se) begin m_phase = P_SERVE; m_ticks = 0; m_dir = 0; end
      P_SERVE: if (frame_tick) begin
        m_ticks++;
        if (m_ticks > SF) begin m_serve = 1; m_phase = P_PLAY; end
      end
      P_PLAY: begin
        if (out_left) begin
          m_s2 = (m_s2 < MAXS) ? m_s2 + 1 : MAXS;
          m_g2 = 1; m_dir = 0; m_phase = P_GOAL; m_ticks = 0;
        end else if (out_right) begin
          m_s1 = (m_s1 < MAXS) ? m_s1 + 1 : MAXS;
          m_g1 = 1; m_dir = 1; m_phase = P_GOAL; m_ticks = 0;
        end else if (pe) m_phase = P_PAUSED;
      end
      P_PAUSED: if (pe) m_phase = P_PLAY;
      P_GOAL: if (frame_tick) begin
        m_g1 = 0; m_g2 = 0;
        m_ticks++;
        if (m_ticks > GF) begin
          m_phase = (m_winner() != 0) ? P_OVER : P_SERVE;
          m_ticks = 0;
        end
      end
      default: if (se) begin m_phase = P_IDLE; m_s1 = 0; m_s2 = 0; end
    endcase
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("m_state", int'(state), m_phase);
    chk("m_goal1", int'(goal_ply1), int'(m_g1));
    chk("m_goal2", int'(goal_ply2), int'(m_g2));
    chk("m_serve", int'(serve), int'(m_serve));
    chk("m_dir", int'(ball_dir), int'(m_dir));
    chk("m_freeze", int'(freeze), (m_phase != P_PLAY) ? 1 : 0);
    chk("m_clr", int'(score_clr), (m_phase == P_IDLE) ? 1 : 0);
    chk("m_winner", int'(winner), m_winner());
  endtask

  task automatic cycle(input bit r, t, st, pa, l, rr);
    @(negedge px_clk);
    reset = r; frame_tick = t; start = st; pause = pa; out_left = l; out_right = rr;
    @(posedge px_clk);
    model_step();
    cyc++;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r, t, st, pa, l, rr;
    logic [2:0] s;
    bit g1, g2, sv, fz, clr;
    logic [1:0] w;
    bit d;
  } vec_t;

  vec_t vec[$];

  task automatic row(input bit r, t, st, pa, l, rr, input logic [2:0] s,
                     input bit g1, g2, sv, fz, clr, input logic [1:0] w, input bit d);
    vec_t v;
    v.r = r; v.t = t; v.st = st; v.pa = pa; v.l = l; v.rr = rr;
    v.s = s; v.g1 = g1; v.g2 = g2; v.sv = sv; v.fz = fz; v.clr = clr; v.w = w; v.d = d;
    vec.push_back(v);
  endtask

  initial begin
    // reset with start held: start edge seen on the first cycle out of reset
    row(1,0,1,0,0,0, IDL,0,0,0,1,1,2'b00,0);
    row(0,0,1,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,1,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,0,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, PLY,0,0,1,0,0,2'b00,0);
    row(0,0,0,0,0,0, PLY,0,0,0,0,0,2'b00,0);
    // point to player 1, strobe held until a tick in GOAL
    row(0,0,0,0,0,1, GOL,1,0,0,1,0,2'b00,1);
    row(0,0,0,0,0,0, GOL,1,0,0,1,0,2'b00,1);
    row(0,1,0,0,0,0, GOL,0,0,0,1,0,2'b00,1);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
    row(0,1,0,0,0,0, PLY,0,0,1,0,0,2'b00,1);
    // both outs together: only player 2 scores
    row(0,0,0,0,1,1, GOL,0,1,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, GOL,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, PLY,0,0,1,0,0,2'b00,0);
    // pause / resume, outs ignored while paused
    row(0,0,0,1,0,0, PSD,0,0,0,1,0,2'b00,0);
    row(0,0,0,1,1,0, PSD,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, PSD,0,0,0,1,0,2'b00,0);
    row(0,0,0,1,0,0, PLY,0,0,0,0,0,2'b00,0);
    // reset mid-GOAL with goal_ply2 high
    row(0,0,0,0,1,0, GOL,0,1,0,1,0,2'b00,0);
    row(1,0,0,0,0,0, IDL,0,0,0,1,1,2'b00,0);
    row(0,0,0,0,0,0, IDL,0,0,0,1,1,2'b00,0);
    // full game to MAX_SCORE by player 1
    row(0,0,1,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,0);
    row(0,1,0,0,0,0, PLY,0,0,1,0,0,2'b00,0);
    for (int k = 1; k <= 3; k++) begin
      row(0,0,0,0,0,1, GOL,1,0,0,1,0,(k == 3) ? 2'b01 : 2'b00,1);
      row(0,1,0,0,0,0, GOL,0,0,0,1,0,(k == 3) ? 2'b01 : 2'b00,1);
      if (k < 3) begin
        row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
        row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
        row(0,1,0,0,0,0, SRV,0,0,0,1,0,2'b00,1);
        row(0,1,0,0,0,0, PLY,0,0,1,0,0,2'b00,1);
      end else begin
        row(0,1,0,0,0,0, OVR,0,0,0,1,0,2'b01,1);
      end
    end
    row(0,1,0,1,0,0, OVR,0,0,0,1,0,2'b01,1);
    row(0,0,1,0,0,0, IDL,0,0,0,1,1,2'b00,1);
    row(0,0,1,0,0,0, IDL,0,0,0,1,1,2'b00,1);
    row(0,0,0,0,0,0, IDL,0,0,0,1,1,2'b00,1);
    row(0,0,1,0,0,0, SRV,0,0,0,1,0,2'b00,0);

    foreach (vec[i]) begin
      cycle(vec[i].r, vec[i].t, vec[i].st, vec[i].pa, vec[i].l, vec[i].rr);
      chk("v_state", int'(state), int'(vec[i].s));
      chk("v_goal1", int'(goal_ply1), int'(vec[i].g1));
      chk("v_goal2", int'(goal_ply2), int'(vec[i].g2));
      chk("v_serve", int'(serve), int'(vec[i].sv));
      chk("v_freeze", int'(freeze), int'(vec[i].fz));
      chk("v_clr", int'(score_clr), int'(vec[i].clr));
      chk("v_winner", int'(winner), int'(vec[i].w));
      chk("v_dir", int'(ball_dir), int'(vec[i].d));
      chk_model();
    end

    // ---------------- random traffic ----------------
    begin
      bit st_l, pa_l;
      st_l = 1'b1;
      pa_l = 1'b0;
      for (int n = 0; n < 5000; n++) begin
        bit r, t, l, rr;
        if ($urandom_range(0, 29) == 0) st_l = ~st_l;
        if ($urandom_range(0, 39) == 0) pa_l = ~pa_l;
        r  = ($urandom_range(0, 599) == 0);
        t  = ($urandom_range(0, 2) == 0);
        l  = ($urandom_range(0, 19) == 0);
        rr = ($urandom_range(0, 17) == 0);
        cycle(r, t, st_l, pa_l, l, rr);
        chk_model();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
# match_controller

Game sequencer for the Pong stage: owns the match state machine that drives the two scoreboard goal counters and the ball. Converts ball-out events into per-player goal strobes and a score-clear level for the scoreboard, and holds the ball frozen or launches it through serve, goal-pause, pause and game-over phases. Shadow score counters detect the winning score. Sits between the ball/collision logic and the scoreboard in the pixel-clock domain.

## Interface

Parameters:
- MAX_SCORE, 9, winning score; legal 1..9 (scoreboard digit range)
- SERVE_FRAMES, 60, frame_tick count before a serve; legal 0..255
- GOAL_FRAMES, 90, frame_tick count of post-goal pause; legal 0..255

Ports:
- px_clk  in  1  pixel clock; only clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle strobe once per frame (same rate as the scoreboard dynamic clock)
- start  in  1  start/restart button level
- pause  in  1  pause button level
- out_left  in  1  ball beyond player 1 edge; point to player 2
- out_right  in  1  ball beyond player 2 edge; point to player 1
- goal_ply1  out  1  increment strobe to player 1 counter
- goal_ply2  out  1  increment strobe to player 2 counter
- score_clr  out  1  scoreboard reset level
- serve  out  1  one-cycle ball launch pulse
- ball_dir  out  1  serve direction; 0 = toward player 1, 1 = toward player 2
- freeze  out  1  hold ball position
- winner  out  2  01 = player 1, 10 = player 2, 00 = none
- state  out  3  current state encoding

## Operation

- States/encoding: IDLE 000, SERVE 001, PLAY 010, PAUSED 011, GOAL 100, GAMEOVER 101; 110/111 go to IDLE next cycle.
- Edge detect: start_q/pause_q registered, reset to 0; start_e = start & ~start_q, same for pause. A button held through reset yields an edge on the first post-reset cycle.
- Shadow scores s1, s2: 4-bit, cleared in IDLE, saturate at MAX_SCORE.
- Frame counter fc: 8-bit.
- IDLE: score_clr=1, freeze=1, winner=00. start_e -> SERVE; fc <= SERVE_FRAMES; ball_dir <= 0.
- SERVE: freeze=1. On frame_tick: if fc==0, serve pulse and -> PLAY; else fc--. Serve occurs on the (SERVE_FRAMES+1)th frame_tick.
- PLAY: freeze=0. Priority, highest first: out_left, out_right, pause_e.
  - out_left: s2++, goal_ply2 <= 1, ball_dir <= 0, -> GOAL.
  - out_right: s1++, goal_ply1 <= 1, ball_dir <= 1, -> GOAL.
  - Both outs same cycle: out_left wins; only player 2 scores.
  - On either goal: fc <= GOAL_FRAMES; if the incremented score == MAX_SCORE, winner <= scorer.
- PAUSED: freeze=1; out_left/out_right ignored; pause_e -> PLAY; no serve re-issued.
- GOAL: freeze=1.
  - goal strobe stays high until the first frame_tick in GOAL, then clears the following cycle, guaranteeing capture by the slow-clocked counters.
  - On frame_tick: if fc==0, -> GAMEOVER when winner!=00, else -> SERVE with fc <= SERVE_FRAMES; else fc--.
- GAMEOVER: freeze=1; winner held; start_e -> IDLE.
- start_e outside IDLE/GAMEOVER and pause_e outside PLAY/PAUSED are ignored.

## Timing

- All outputs registered; state changes visible the cycle after the triggering input is sampled.
- Reset values: state=IDLE, goal_ply1=0, goal_ply2=0, score_clr=1, serve=0, ball_dir=0, freeze=1, winner=00, s1=s2=0, fc=0.
- reset in any state, including mid-GOAL with a strobe high: next cycle equals reset values; strobe dropped.
- serve is exactly one px_clk wide; at most one goal strobe per GOAL visit.
- score_clr is high in every IDLE cycle and low otherwise; it falls the cycle state leaves IDLE.
- SERVE_FRAMES=0 or GOAL_FRAMES=0: transition on the first frame_tick.

## Test plan

- Reset with start held high -> cycle 1 after reset state=SERVE, score_clr=0; with SERVE_FRAMES=2, serve pulses on the 3rd frame_tick, freeze drops the same cycle.
- PLAY, out_right 1 cycle -> goal_ply1=1 until the cycle after the next frame_tick, s1=1, ball_dir=1; after GOAL_FRAMES+1 ticks state=SERVE.
- out_left and out_right asserted in the same cycle -> only goal_ply2 asserted, s2=1, ball_dir=0.
- MAX_SCORE=3, three out_right goals -> winner=01 on the third; after the goal pause state=GAMEOVER; start edge -> IDLE, score_clr=1, winner=00.
- PLAY, pause edge -> PAUSED, freeze=1; out_left pulse ignored (no strobe); second pause edge -> PLAY, no serve pulse.
- reset asserted mid-GOAL with goal_ply2 high -> next cycle all outputs at reset values, state=IDLE.
